wb_sequencer: RTL and testbench



---
 rtl/wb_sequencer_if.sv | 39 +++
 rtl/wb_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// rtl/wb_sequencer_if.sv - write-back sequencer bus bundle (ALU, load, memory, write port, hazards)
interface wb_sequencer_if;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic [1:0]  alu_mode;
   logic        ld_start;
   logic        ld_ready;
   logic [4:0]  ld_addr;
   logic [1:0]  ld_mode;
   logic        mem_valid;
   logic [15:0] mem_data;
   logic        wr_en;
   logic        wr_en_upr;
   logic        wr_en_lwr;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data1;
   logic [15:0] wr_data2;
   logic [31:0] pend_vec;

   modport master (
      output alu_valid, alu_addr, alu_data, alu_mode,
      output ld_start, ld_addr, ld_mode,
      output mem_valid, mem_data,
      input  alu_ready, ld_ready,
      input  wr_en, wr_en_upr, wr_en_lwr, wr_addr, wr_data1, wr_data2,
      input  pend_vec
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, alu_mode,
      input  ld_start, ld_addr, ld_mode,
      input  mem_valid, mem_data,
      output alu_ready, ld_ready,
      output wr_en, wr_en_upr, wr_en_lwr, wr_addr, wr_data1, wr_data2,
      output pend_vec
   );
endinterface

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - merges queued ALU results and half-word loads onto the split-half register write port
module wb_sequencer #(
   parameter int QDEPTH = 2,
   parameter int XLEN   = 32
) (
   input logic           clk,
   input logic           rst,
   wb_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LD_LO = 2'd1,
      LD_HI = 2'd2,
      LD_WR = 2'd3
   } state_t;

   // Strobe pattern for a write mode: {wr_en, upr, lwr}; mode 11 writes nothing
   function automatic logic [2:0] mode_strobes(input logic [1:0] mode);
      case (mode)
         2'b00:   mode_strobes = 3'b100;
         2'b01:   mode_strobes = 3'b110;
         2'b10:   mode_strobes = 3'b101;
         default: mode_strobes = 3'b000;
      endcase
   endfunction

   state_t            state_q, state_d;

   // Two-entry ALU result queue; 1-bit pointers wrap naturally at depth 2
   logic [4:0]        q_addr_q [QDEPTH];
   logic [4:0]        q_addr_d [QDEPTH];
   logic [XLEN-1:0]   q_data_q [QDEPTH];
   logic [XLEN-1:0]   q_data_d [QDEPTH];
   logic [1:0]        q_mode_q [QDEPTH];
   logic [1:0]        q_mode_d [QDEPTH];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;

   // Load context captured at issue and while beats arrive
   logic [4:0]        ld_addr_q, ld_addr_d;
   logic [1:0]        ld_mode_q, ld_mode_d;
   logic [15:0]       lo_q, lo_d;
   logic [15:0]       hi_q, hi_d;

   // Registered write port
   logic              wr_en_q, wr_en_d;
   logic              wr_upr_q, wr_upr_d;
   logic              wr_lwr_q, wr_lwr_d;
   logic [4:0]        wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data1_q, wr_data1_d;
   logic [15:0]       wr_data2_q, wr_data2_d;

   logic              alu_ready_w;
   logic              ld_ready_w;
   logic              alu_fire;
   logic              ld_fire;
   logic              fall_through;
   logic              pop;
   logic              push;
   logic [15:0]       ld_hi_half;
   logic [31:0]       pend_w;

   logic [4:0]        sel_addr;
   logic [XLEN-1:0]   sel_data;
   logic [1:0]        sel_mode;
   logic [2:0]        strobes;

   assign alu_ready_w  = (count_q < 2'(QDEPTH));
   assign ld_ready_w   = (state_q == IDLE) && (count_q == 2'd0) && !wr_en_q;
   assign alu_fire     = bus.alu_valid && alu_ready_w;
   assign ld_fire      = bus.ld_start && ld_ready_w;
   // An accepted result bypasses the queue only when nothing is ahead of it
   assign fall_through = alu_fire && (count_q == 2'd0) && (state_q == IDLE);
   // Draining is held off during a load so later ALU results cannot overtake it
   assign pop          = (state_q == IDLE) && (count_q != 2'd0);
   assign push         = alu_fire && !fall_through;

   // High half of the load result depends on lw / lh / lhu
   always_comb begin
      case (ld_mode_q)
         2'b00:   ld_hi_half = hi_q;
         2'b01:   ld_hi_half = {16{lo_q[15]}};
         default: ld_hi_half = 16'h0000;
      endcase
   end

   // Next state for the queue, load FSM and the registered write port
   always_comb begin
      state_d    = state_q;
      q_addr_d   = q_addr_q;
      q_data_d   = q_data_q;
      q_mode_d   = q_mode_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ld_addr_d  = ld_addr_q;
      ld_mode_d  = ld_mode_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      wr_en_d    = 1'b0;
      wr_upr_d   = 1'b0;
      wr_lwr_d   = 1'b0;
      wr_addr_d  = 5'd0;
      wr_data1_d = 16'h0000;
      wr_data2_d = 16'h0000;
      sel_addr   = 5'd0;
      sel_data   = '0;
      sel_mode   = 2'b11;

      // Choose the single write source for this cycle; sources are mutually exclusive
      if (pop) begin
         sel_addr = q_addr_q[rd_ptr_q];
         sel_data = q_data_q[rd_ptr_q];
         sel_mode = q_mode_q[rd_ptr_q];
         rd_ptr_d = ~rd_ptr_q;
      end else if (fall_through) begin
         sel_addr = bus.alu_addr;
         sel_data = bus.alu_data;
         sel_mode = bus.alu_mode;
      end else if (state_q == LD_WR) begin
         sel_addr = ld_addr_q;
         sel_data = {ld_hi_half, lo_q};
         sel_mode = 2'b00;
      end

      strobes = mode_strobes(sel_mode);
      if (strobes[2]) begin
         wr_en_d    = 1'b1;
         wr_upr_d   = strobes[1];
         wr_lwr_d   = strobes[0];
         wr_addr_d  = sel_addr;
         wr_data1_d = sel_data[XLEN/2-1:0];
         wr_data2_d = sel_data[XLEN-1:XLEN/2];
      end

      if (push) begin
         q_addr_d[wr_ptr_q] = bus.alu_addr;
         q_data_d[wr_ptr_q] = bus.alu_data;
         q_mode_d[wr_ptr_q] = bus.alu_mode;
         wr_ptr_d           = ~wr_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
         IDLE: begin
            if (ld_fire) begin
               ld_addr_d = bus.ld_addr;
               ld_mode_d = bus.ld_mode;
               state_d   = LD_LO;
            end
         end
         LD_LO: begin
            if (bus.mem_valid) begin
               lo_d    = bus.mem_data;
               state_d = (ld_mode_q == 2'b00) ? LD_HI : LD_WR;
            end
         end
         LD_HI: begin
            if (bus.mem_valid) begin
               hi_d    = bus.mem_data;
               state_d = LD_WR;
            end
         end
         LD_WR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pending map: live queue entries that write, the load in flight, and the current strobe
   always_comb begin
      pend_w = 32'd0;
      if (count_q != 2'd0 && q_mode_q[rd_ptr_q] != 2'b11)
         pend_w = pend_w | (32'd1 << q_addr_q[rd_ptr_q]);
      if (count_q == 2'd2 && q_mode_q[~rd_ptr_q] != 2'b11)
         pend_w = pend_w | (32'd1 << q_addr_q[~rd_ptr_q]);
      if (state_q != IDLE)
         pend_w = pend_w | (32'd1 << ld_addr_q);
      if (wr_en_q)
         pend_w = pend_w | (32'd1 << wr_addr_q);
   end

   // All state registers; reset wins over every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         q_addr_q   <= '{default: '0};
         q_data_q   <= '{default: '0};
         q_mode_q   <= '{default: '0};
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         ld_addr_q  <= 5'd0;
         ld_mode_q  <= 2'b00;
         lo_q       <= 16'h0000;
         hi_q       <= 16'h0000;
         wr_en_q    <= 1'b0;
         wr_upr_q   <= 1'b0;
         wr_lwr_q   <= 1'b0;
         wr_addr_q  <= 5'd0;
         wr_data1_q <= 16'h0000;
         wr_data2_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         q_addr_q   <= q_addr_d;
         q_data_q   <= q_data_d;
         q_mode_q   <= q_mode_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ld_addr_q  <= ld_addr_d;
         ld_mode_q  <= ld_mode_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         wr_en_q    <= wr_en_d;
         wr_upr_q   <= wr_upr_d;
         wr_lwr_q   <= wr_lwr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data1_q <= wr_data1_d;
         wr_data2_q <= wr_data2_d;
      end
   end

   assign bus.alu_ready = alu_ready_w;
   assign bus.ld_ready  = ld_ready_w;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_en_upr = wr_upr_q;
   assign bus.wr_en_lwr = wr_lwr_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data1  = wr_data1_q;
   assign bus.wr_data2  = wr_data2_q;
   assign bus.pend_vec  = pend_w;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - directed and randomized bench for wb_sequencer against a transaction-order model
module tb_wb_sequencer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wb_sequencer_if bus ();

   wb_sequencer #(.QDEPTH(2), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // kind: 0 full, 1 upper-only, 2 lower-only
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [1:0]  kind;
      bit          is_load;
   } wr_t;

   wr_t         exp_q[$];
   int          outst[32];
   logic [31:0] model_rf[32];
   logic [31:0] shadow_rf[32];
   int          n_tests = 0;
   int          n_fail  = 0;

   bit          ld_active;
   int          beats_left;
   logic [1:0]  ld_md;
   logic [15:0] ld_lo;
   logic [15:0] ld_hi;

   logic [31:0] val_a;
   logic [31:0] val_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pend_model();
      logic [31:0] m;
      m = 32'd0;
      for (int r = 0; r < 32; r++)
         if (outst[r] > 0) m[r] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      for (int r = 0; r < 32; r++) outst[r] = 0;
      ld_active  = 1'b0;
      beats_left = 0;
   endtask

   task automatic set_idle();
      bus.alu_valid = 1'b0;
      bus.alu_addr  = 5'd0;
      bus.alu_data  = 32'd0;
      bus.alu_mode  = 2'b00;
      bus.ld_start  = 1'b0;
      bus.ld_addr   = 5'd0;
      bus.ld_mode   = 2'b00;
      bus.mem_valid = 1'b0;
      bus.mem_data  = 16'd0;
   endtask

   // Record what the coming edge accepts, in program order (ALU before a same-cycle load)
   task automatic commit();
      wr_t e;
      logic [31:0] d;
      if (rst) begin
         model_reset();
         return;
      end
      if (bus.alu_valid && bus.alu_ready && bus.alu_mode != 2'b11) begin
         e.addr = bus.alu_addr; e.data = bus.alu_data; e.kind = bus.alu_mode; e.is_load = 1'b0;
         exp_q.push_back(e);
         outst[bus.alu_addr]++;
      end
      if (bus.ld_start && bus.ld_ready) begin
         ld_active  = 1'b1;
         ld_md      = bus.ld_mode;
         beats_left = (bus.ld_mode == 2'b00) ? 2 : 1;
         e.addr = bus.ld_addr; e.data = 'x; e.kind = 2'd0; e.is_load = 1'b1;
         exp_q.push_back(e);
         outst[bus.ld_addr]++;
      end else if (ld_active && beats_left > 0 && bus.mem_valid) begin
         if (ld_md == 2'b00 && beats_left == 1) ld_hi = bus.mem_data;
         else ld_lo = bus.mem_data;
         beats_left--;
         if (beats_left == 0) begin
            case (ld_md)
               2'b00:   d = {ld_hi, ld_lo};
               2'b01:   d = {{16{ld_lo[15]}}, ld_lo};
               default: d = {16'h0000, ld_lo};
            endcase
            for (int i = 0; i < exp_q.size(); i++)
               if (exp_q[i].is_load) exp_q[i].data = d;
            ld_active = 1'b0;
         end
      end
   endtask

   // Compare the write port and hazard map against the model, then retire the observed write
   task automatic check_cycle();
      wr_t e;
      chk("pend_vec", bus.pend_vec, pend_model());
      chk("upr_lwr_excl", {31'd0, bus.wr_en_upr & bus.wr_en_lwr}, 32'd0);
      if (bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_wr_addr", {27'd0, bus.wr_addr}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.addr});
            chk("wr_strobes", {30'd0, bus.wr_en_upr, bus.wr_en_lwr},
                (e.kind == 2'd1) ? 32'd2 : (e.kind == 2'd2) ? 32'd1 : 32'd0);
            case (e.kind)
               2'd1: begin
                  chk("wr_data2", {16'd0, bus.wr_data2}, {16'd0, e.data[31:16]});
                  model_rf[e.addr][31:16] = e.data[31:16];
               end
               2'd2: begin
                  chk("wr_data1", {16'd0, bus.wr_data1}, {16'd0, e.data[15:0]});
                  model_rf[e.addr][15:0] = e.data[15:0];
               end
               default: begin
                  chk("wr_data", {bus.wr_data2, bus.wr_data1}, e.data);
                  model_rf[e.addr] = e.data;
               end
            endcase
            outst[e.addr]--;
         end
         if (bus.wr_en_upr) shadow_rf[bus.wr_addr][31:16] = bus.wr_data2;
         else if (bus.wr_en_lwr) shadow_rf[bus.wr_addr][15:0] = bus.wr_data1;
         else shadow_rf[bus.wr_addr] = {bus.wr_data2, bus.wr_data1};
      end
   endtask

   task automatic tick();
      commit();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic run_load(input logic [4:0] a, input logic [1:0] m,
                           input logic [15:0] lo, input logic [15:0] hi);
      chk("ld_ready_pre", {31'd0, bus.ld_ready}, 32'd1);
      bus.ld_start = 1'b1; bus.ld_addr = a; bus.ld_mode = m;
      tick();
      bus.ld_start = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_data = lo;
      tick();
      if (m == 2'b00) begin
         bus.mem_data = hi;
         tick();
      end
      bus.mem_valid = 1'b0;
      tick();
   endtask

   task automatic rand_drive(input bit allow_new);
      bus.alu_valid = allow_new && ($urandom_range(0, 2) == 0);
      bus.alu_addr  = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.alu_mode  = 2'($urandom_range(0, 3));
      bus.ld_start  = allow_new && !ld_active && ($urandom_range(0, 5) == 0);
      bus.ld_addr   = 5'($urandom_range(0, 7));
      bus.ld_mode   = 2'($urandom_range(0, 3));
      if (ld_active && beats_left > 0) bus.mem_valid = ($urandom_range(0, 1) == 1);
      else bus.mem_valid = ($urandom_range(0, 9) == 0);
      bus.mem_data  = 16'($urandom);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         model_rf[r]  = 32'd0;
         shadow_rf[r] = 32'd0;
      end
      model_reset();
      set_idle();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("rst_wr_data", {bus.wr_data2, bus.wr_data1}, 32'd0);
      chk("rst_pend", bus.pend_vec, 32'd0);
      chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
      chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      rst = 1'b0;

      // Fall-through full write, latency 1
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h1234ABCD; bus.alu_mode = 2'b00;
      tick();
      set_idle();
      chk("t1_wr_en", {31'd0, bus.wr_en}, 32'd1);
      chk("t1_wr_addr", {27'd0, bus.wr_addr}, 32'd5);
      chk("t1_data", {bus.wr_data2, bus.wr_data1}, 32'h1234ABCD);
      chk("t1_pend5", {31'd0, bus.pend_vec[5]}, 32'd1);
      tick();
      chk("t1_wr_en_after", {31'd0, bus.wr_en}, 32'd0);
      chk("t1_pend5_after", {31'd0, bus.pend_vec[5]}, 32'd0);

      // Upper-only then lower-only to r7 on consecutive cycles
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'hBEEF0000; bus.alu_mode = 2'b01;
      tick();
      bus.alu_data = 32'h0000CAFE; bus.alu_mode = 2'b10;
      chk("t2_upr", {29'd0, bus.wr_en, bus.wr_en_upr, bus.wr_en_lwr}, 32'd6);
      chk("t2_data2", {16'd0, bus.wr_data2}, 32'h0000BEEF);
      tick();
      set_idle();
      chk("t2_lwr", {29'd0, bus.wr_en, bus.wr_en_upr, bus.wr_en_lwr}, 32'd5);
      chk("t2_data1", {16'd0, bus.wr_data1}, 32'h0000CAFE);
      tick();

      // lw to r9 with three idle cycles between beats
      chk("t3_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      bus.ld_start = 1'b1; bus.ld_addr = 5'd9; bus.ld_mode = 2'b00;
      tick();
      bus.ld_start = 1'b0;
      chk("t3_pend9_start", {31'd0, bus.pend_vec[9]}, 32'd1);
      bus.mem_valid = 1'b1; bus.mem_data = 16'h5678;
      tick();
      bus.mem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_no_wr_gap", {31'd0, bus.wr_en}, 32'd0);
      end
      bus.mem_valid = 1'b1; bus.mem_data = 16'h1234;
      tick();
      bus.mem_valid = 1'b0;
      chk("t3_no_wr_beat", {31'd0, bus.wr_en}, 32'd0);
      tick();
      chk("t3_wr_en", {29'd0, bus.wr_en, bus.wr_en_upr, bus.wr_en_lwr}, 32'd4);
      chk("t3_wr_addr", {27'd0, bus.wr_addr}, 32'd9);
      chk("t3_data", {bus.wr_data2, bus.wr_data1}, 32'h12345678);
      tick();
      chk("t3_pend9_after", {31'd0, bus.pend_vec[9]}, 32'd0);

      // lh sign-extends, lhu zero-extends
      run_load(5'd3, 2'b01, 16'h8001, 16'h0000);
      chk("t4_lh_data", {bus.wr_data2, bus.wr_data1}, 32'hFFFF8001);
      tick();
      run_load(5'd3, 2'b10, 16'h8001, 16'h0000);
      chk("t4_lhu_data", {bus.wr_data2, bus.wr_data1}, 32'h00008001);
      tick();

      // ALU results behind an in-flight lw keep their order and fill the queue
      val_a = $urandom;
      val_b = $urandom;
      bus.ld_start = 1'b1; bus.ld_addr = 5'd4; bus.ld_mode = 2'b00;
      tick();
      bus.ld_start = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = val_a; bus.alu_mode = 2'b00;
      tick();
      bus.alu_addr = 5'd6; bus.alu_data = val_b;
      tick();
      chk("t5_alu_ready_full", {31'd0, bus.alu_ready}, 32'd0);
      bus.alu_addr = 5'd6; bus.alu_data = ~val_b;
      tick();
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_data = 16'h1111;
      tick();
      bus.mem_data = 16'h2222;
      tick();
      set_idle();
      for (int i = 0; i < 5; i++) tick();
      chk("t5_r4_final", shadow_rf[4], val_a);
      chk("t5_r6_final", shadow_rf[6], val_b);

      // Reset during LD_HI abandons the load; a late beat is ignored
      bus.ld_start = 1'b1; bus.ld_addr = 5'd10; bus.ld_mode = 2'b00;
      tick();
      bus.ld_start = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_data = 16'hAAAA;
      tick();
      bus.mem_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      chk("t6_pend", bus.pend_vec, 32'd0);
      bus.mem_valid = 1'b1; bus.mem_data = 16'hBEEF;
      tick();
      bus.mem_valid = 1'b0;
      chk("t6_no_wr", {31'd0, bus.wr_en}, 32'd0);
      chk("t6_pend_after", bus.pend_vec, 32'd0);
      tick();
      chk("t6_no_wr2", {31'd0, bus.wr_en}, 32'd0);

      // Randomized traffic against the ordering model
      for (int i = 0; i < 800; i++) begin
         rand_drive(1'b1);
         tick();
      end
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && !ld_active) break;
         rand_drive(1'b0);
         tick();
      end
      set_idle();
      tick();
      tick();
      chk("drain_empty", exp_q.size(), 32'd0);
      for (int r = 0; r < 32; r++)
         chk($sformatf("regfile_r%0d", r), shadow_rf[r], model_rf[r]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
